// File: rtl/bicubic_coeff_pkg.sv
// Shared widths, types, FSM encoding and the power-on coefficient table for the bicubic loader.
// Default table: line 0 ramps {64-4w, 4w}, line 1 ramps {-w, 128-w}, both in signed 9-bit halves.
package bicubic_coeff_pkg;

    localparam int COEFF_W = 9;
    localparam int WORDS   = 16;
    localparam int LINES   = 2;
    localparam int DSP_W   = 2 * COEFF_W;
    localparam int IDX_W   = 6;
    localparam int BUS_W   = DSP_W * WORDS;

    typedef logic [17:0] coeff_word_t;
    typedef coeff_word_t coeff_bank_t [LINES][WORDS];

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PEND
    } loader_state_e;

    localparam coeff_bank_t BICUBIC_COEFF_DEFAULT = '{
        '{18'h08000, 18'h07804, 18'h07008, 18'h0680C, 18'h06010, 18'h05814, 18'h05018, 18'h0481C,
          18'h04020, 18'h03824, 18'h03028, 18'h0282C, 18'h02030, 18'h01834, 18'h01038, 18'h0083C},
        '{18'h00080, 18'h3FE7F, 18'h3FC7E, 18'h3FA7D, 18'h3F87C, 18'h3F67B, 18'h3F47A, 18'h3F279,
          18'h3F078, 18'h3EE77, 18'h3EC76, 18'h3EA75, 18'h3E874, 18'h3E673, 18'h3E472, 18'h3E271}
    };

endpackage

// File: rtl/bicubic_coeff_packer.sv
// Pairs hi/lo coefficient beats into DSP words and tracks the 6-bit stream index.
// Write strobe and error/final flags are combinational on the accepted beat; no backpressure of its own.
module bicubic_coeff_packer
    import bicubic_coeff_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_beat,
    input  logic [COEFF_W-1:0] i_data,
    input  logic               i_last,
    output logic               o_line,
    output logic [3:0]         o_word,
    output coeff_word_t        o_data,
    output logic               o_we,
    output logic               o_final,
    output logic               o_err
);

    logic [IDX_W-1:0]   r_idx;
    logic [COEFF_W-1:0] r_hi;
    logic               w_at_end;

    assign w_at_end = (r_idx == IDX_W'(LINES * WORDS * 2 - 1));
    assign o_err    = i_beat && (i_last != w_at_end);
    assign o_final  = i_beat && i_last && w_at_end;
    assign o_we     = i_beat && r_idx[0];
    assign o_line   = r_idx[5];
    assign o_word   = r_idx[4:1];
    assign o_data   = {r_hi, i_data};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx <= '0;
            r_hi  <= '0;
        end else if (i_beat) begin
            if (!r_idx[0]) begin
                r_hi <= i_data;
            end
            // an aborted load restarts at line 0 word 0 hi
            if (o_err || o_final) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bicubic_coeff_loader.sv
// Double-buffered bicubic coefficient table; shadow swaps to active on frame_start after a full load.
// coeff_dsp_o and pulses are registered (1 cycle); ready drops in PEND. BICUBIC_COEFF_READBACK_EN adds rd_* ports.
module bicubic_coeff_loader
    import bicubic_coeff_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               s_coeff_valid,
    output logic               s_coeff_ready,
    input  logic [COEFF_W-1:0] s_coeff_data,
    input  logic               s_coeff_last,
    input  logic               frame_start,
    input  logic               line,
    output logic [BUS_W-1:0]   coeff_dsp_o,
    output logic               load_done,
    output logic               load_err
`ifdef BICUBIC_COEFF_READBACK_EN
    ,
    input  logic               rd_sel,
    input  logic               rd_line,
    input  logic [3:0]         rd_word,
    output logic [DSP_W-1:0]   rd_data
`endif
);

    loader_state_e r_state;
    loader_state_e w_state_nxt;
    coeff_bank_t   r_active;
    coeff_bank_t   r_shadow;
    logic          r_load_done;
    logic          r_load_err;
    logic [BUS_W-1:0] r_dsp;
    logic [BUS_W-1:0] w_dsp_nxt;
    logic [BUS_W-1:0] w_dsp_def;
    logic          w_beat;
    logic          w_swap;
    logic          w_line;
    logic [3:0]    w_word;
    coeff_word_t   w_data;
    logic          w_we;
    logic          w_final;
    logic          w_err;

    assign s_coeff_ready = (r_state != PEND);
    assign w_beat        = s_coeff_valid && s_coeff_ready;

    bicubic_coeff_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .i_beat  (w_beat),
        .i_data  (s_coeff_data),
        .i_last  (s_coeff_last),
        .o_line  (w_line),
        .o_word  (w_word),
        .o_data  (w_data),
        .o_we    (w_we),
        .o_final (w_final),
        .o_err   (w_err)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_done <= w_swap;
            r_load_err  <= w_err;
        end
    end

    // frame_start outside PEND is ignored; a final beat coinciding with it only reaches PEND
    always_comb begin
        w_state_nxt = r_state;
        w_swap      = 1'b0;
        case (r_state)
            IDLE, LOAD: begin
                if (w_err) begin
                    w_state_nxt = IDLE;
                end else if (w_final) begin
                    w_state_nxt = PEND;
                end else if (w_beat) begin
                    w_state_nxt = LOAD;
                end
            end
            PEND: begin
                if (frame_start) begin
                    w_state_nxt = IDLE;
                    w_swap      = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= BICUBIC_COEFF_DEFAULT;
        end else if (w_we) begin
            r_shadow[w_line][w_word] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_active <= BICUBIC_COEFF_DEFAULT;
        end else if (w_swap) begin
            r_active <= r_shadow;
        end
    end

    always_comb begin
        w_dsp_nxt = '0;
        w_dsp_def = '0;
        for (int w = 0; w < WORDS; w++) begin
            w_dsp_nxt[w*DSP_W +: DSP_W] = r_active[line][w];
            w_dsp_def[w*DSP_W +: DSP_W] = BICUBIC_COEFF_DEFAULT[0][w];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dsp <= w_dsp_def;
        end else begin
            r_dsp <= w_dsp_nxt;
        end
    end

    assign coeff_dsp_o = r_dsp;
    assign load_done   = r_load_done;
    assign load_err    = r_load_err;

`ifdef BICUBIC_COEFF_READBACK_EN
    logic [DSP_W-1:0] r_rd_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (rd_sel) begin
            r_rd_data <= r_shadow[rd_line][rd_word];
        end else begin
            r_rd_data <= r_active[rd_line][rd_word];
        end
    end

    assign rd_data = r_rd_data;
`endif

endmodule

// File: tb/tb_bicubic_coeff_loader.sv
// Scoreboard bench for bicubic_coeff_loader: expected bus words queued at stimulus, popped at output.
module tb_bicubic_coeff_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_coeff_valid;
    logic         s_coeff_ready;
    logic [8:0]   s_coeff_data;
    logic         s_coeff_last;
    logic         frame_start;
    logic         line;
    logic [287:0] coeff_dsp_o;
    logic         load_done;
    logic         load_err;
`ifdef BICUBIC_COEFF_READBACK_EN
    logic         rd_sel;
    logic         rd_line;
    logic [3:0]   rd_word;
    logic [17:0]  rd_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [17:0]  m_active [2][16];
    logic [17:0]  m_shadow [2][16];
    logic [287:0] exp_q [$];

    bicubic_coeff_loader dut (
        .clk           (clk),
        .rst           (rst),
        .s_coeff_valid (s_coeff_valid),
        .s_coeff_ready (s_coeff_ready),
        .s_coeff_data  (s_coeff_data),
        .s_coeff_last  (s_coeff_last),
        .frame_start   (frame_start),
        .line          (line),
        .coeff_dsp_o   (coeff_dsp_o),
        .load_done     (load_done),
        .load_err      (load_err)
`ifdef BICUBIC_COEFF_READBACK_EN
        ,
        .rd_sel        (rd_sel),
        .rd_line       (rd_line),
        .rd_word       (rd_word),
        .rd_data       (rd_data)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [287:0] got, input logic [287:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [17:0] def_word(input int l, input int w);
        logic signed [8:0] hi;
        logic signed [8:0] lo;
        if (l == 0) begin
            hi = 9'(64 - 4 * w);
            lo = 9'(4 * w);
        end else begin
            hi = 9'(-w);
            lo = 9'(128 - w);
        end
        return {hi, lo};
    endfunction

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            for (int w = 0; w < 16; w++) begin
                m_active[l][w] = def_word(l, w);
                m_shadow[l][w] = def_word(l, w);
            end
        end
    endtask

    task automatic check_line(input logic l, input string tag);
        logic [287:0] e;
        line = l;
        for (int w = 0; w < 16; w++) begin
            e[w*18 +: 18] = m_active[l][w];
        end
        exp_q.push_back(e);
        tick();
        chk(tag, coeff_dsp_o, exp_q.pop_front());
    endtask

    task automatic send_beat(input logic [8:0] d, input bit lst, input bit rnd, input bit fs);
        bit acc;
        acc = 1'b0;
        if (rnd && ($urandom_range(0, 1) == 1)) begin
            s_coeff_valid = 1'b0;
            tick();
        end
        s_coeff_valid = 1'b1;
        s_coeff_data  = d;
        s_coeff_last  = lst;
        frame_start   = fs;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = s_coeff_ready;
            tick();
        end
        frame_start = 1'b0;
        if (!acc) begin
            chk("beat_accept", {287'd0, acc}, 288'd1);
        end
    endtask

    // n beats of pattern k: hi=w+1+k, lo=-(w+1+k), line 1 negated; last only on beat n when last_n
    task automatic load_table(input int k, input bit rnd, input bit fs_last, input int n, input bit last_n);
        logic signed [8:0] hi;
        logic signed [8:0] lo;
        logic signed [8:0] v;
        for (int b = 0; b < n; b++) begin
            int l;
            int w;
            l = b / 32;
            w = (b % 32) / 2;
            hi = 9'(w + 1 + k);
            lo = -hi;
            if (l == 1) begin
                hi = -hi;
                lo = -lo;
            end
            v = (b % 2 == 0) ? hi : lo;
            if (b % 2 == 1) begin
                m_shadow[l][w] = {hi, lo};
            end
            send_beat(v, last_n && (b == n - 1), rnd, fs_last && (b == n - 1));
        end
        s_coeff_valid = 1'b0;
        s_coeff_last  = 1'b0;
    endtask

    task automatic swap_and_check(input string tag);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk({tag, "_done"}, {287'd0, load_done}, 288'd1);
        for (int l = 0; l < 2; l++) begin
            for (int w = 0; w < 16; w++) begin
                m_active[l][w] = m_shadow[l][w];
            end
        end
        check_line(1'b0, {tag, "_line0"});
        chk({tag, "_done_clr"}, {287'd0, load_done}, 288'd0);
        check_line(1'b1, {tag, "_line1"});
    endtask

    initial begin
        rst = 1'b1;
        s_coeff_valid = 1'b0;
        s_coeff_data = '0;
        s_coeff_last = 1'b0;
        frame_start = 1'b0;
        line = 1'b0;
`ifdef BICUBIC_COEFF_READBACK_EN
        rd_sel = 1'b0;
        rd_line = 1'b0;
        rd_word = '0;
`endif
        model_reset();
        repeat (2) tick();
        begin
            logic [287:0] e;
            for (int w = 0; w < 16; w++) e[w*18 +: 18] = def_word(0, w);
            chk("rst_dsp", coeff_dsp_o, e);
        end
        chk("rst_ready", {287'd0, s_coeff_ready}, 288'd1);
        chk("rst_done", {287'd0, load_done}, 288'd0);
        chk("rst_err", {287'd0, load_err}, 288'd0);
`ifdef BICUBIC_COEFF_READBACK_EN
        chk("rst_rd", {270'd0, rd_data}, 288'd0);
`endif
        rst = 1'b0;
        check_line(1'b0, "def_line0");
        check_line(1'b1, "def_line1");

        // full load, swap, spot-check word 3 of line 0
        load_table(0, 1'b0, 1'b0, 64, 1'b1);
        chk("pend_ready", {287'd0, s_coeff_ready}, 288'd0);
        swap_and_check("load1");
        line = 1'b0;
        tick();
        chk("load1_w3", {270'd0, coeff_dsp_o[3*18 +: 18]}, {270'd0, 18'h009FC});

        // early last aborts; active untouched; next load succeeds
        load_table(1, 1'b0, 1'b0, 10, 1'b1);
        chk("early_err", {287'd0, load_err}, 288'd1);
        tick();
        chk("early_err_clr", {287'd0, load_err}, 288'd0);
        chk("early_ready", {287'd0, s_coeff_ready}, 288'd1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("early_nodone", {287'd0, load_done}, 288'd0);
        check_line(1'b0, "early_line0");
        check_line(1'b1, "early_line1");

        // missing last on beat 64 also aborts
        load_table(3, 1'b0, 1'b0, 64, 1'b0);
        chk("nolast_err", {287'd0, load_err}, 288'd1);
        chk("nolast_ready", {287'd0, s_coeff_ready}, 288'd1);
        check_line(1'b1, "nolast_line1");

        load_table(2, 1'b0, 1'b0, 64, 1'b1);
        swap_and_check("load2");

        // final beat together with frame_start: no swap until the next strobe
        load_table(4, 1'b0, 1'b1, 64, 1'b1);
        chk("same_nodone", {287'd0, load_done}, 288'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("same_pend_ready", {287'd0, s_coeff_ready}, 288'd0);
        end
        check_line(1'b0, "same_old_line0");
`ifdef BICUBIC_COEFF_READBACK_EN
        rd_sel = 1'b1;
        rd_line = 1'b1;
        rd_word = 4'd15;
        tick();
        chk("rd_shadow", {270'd0, rd_data}, {270'd0, m_shadow[1][15]});
        rd_sel = 1'b0;
        tick();
        chk("rd_active", {270'd0, rd_data}, {270'd0, m_active[1][15]});
`endif
        swap_and_check("same");

        // gappy valid reproduces the first load
        load_table(0, 1'b1, 1'b0, 64, 1'b1);
        swap_and_check("rnd");
        line = 1'b0;
        tick();
        chk("rnd_w3", {270'd0, coeff_dsp_o[3*18 +: 18]}, {270'd0, 18'h009FC});

        // reset mid-load restores defaults and idles the FSM
        load_table(5, 1'b1, 1'b0, 29, 1'b0);
        rst = 1'b1;
        model_reset();
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", {287'd0, s_coeff_ready}, 288'd1);
        chk("mid_rst_err", {287'd0, load_err}, 288'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("mid_rst_nodone", {287'd0, load_done}, 288'd0);
        check_line(1'b0, "mid_rst_line0");
        check_line(1'b1, "mid_rst_line1");

        load_table(6, 1'b0, 1'b0, 64, 1'b1);
        swap_and_check("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
